// File: rtl/udp_img_rx.sv
// Turns UDP payload bytes (one format header packet, then one packet per line) into RGB565 pixel strobes.
// A pixel appears one clk after its second byte; the block has no backpressure and must keep up with udp_rx_en.
module udp_img_rx #(
  parameter int          MAX_H  = 1280,
  parameter int          MAX_V  = 720,
  parameter logic [7:0]  FORMAT = 8'h04,
  parameter logic [31:0] MAGIC  = 32'hF05AA50F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        udp_rx_en,
  input  logic [7:0]  udp_idata,
  input  logic        udp_rx_done,
  input  logic        resync,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        sof,
  output logic        eol,
  output logic        frame_done,
  output logic        hdr_lock,
  output logic [15:0] img_h,
  output logic [15:0] img_v,
  output logic        err_hdr,
  output logic        err_line
);

  localparam logic [15:0] MAX_H16 = 16'(MAX_H);
  localparam logic [15:0] MAX_V16 = 16'(MAX_V);

  typedef enum logic [1:0] {IDLE, HDR, DROP, LINE} state_t;

  state_t      state;
  logic [3:0]  byte_idx;
  logic [15:0] hdr_h;
  logic [15:0] hdr_v;
  logic [10:0] x;
  logic [10:0] y;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        ovf;

  // Header parsing: the byte arriving in IDLE is header byte 0.
  logic [3:0]  hidx;
  logic [3:0]  cnt_nxt;
  logic [7:0]  exp_byte;
  logic        hdr_bad;
  logic        hdr_ok;
  logic [15:0] h_nxt;
  logic [15:0] v_nxt;

  always_comb begin
    hidx     = (state == HDR) ? byte_idx : 4'd0;
    cnt_nxt  = hidx;
    h_nxt    = hdr_h;
    v_nxt    = hdr_v;
    hdr_bad  = 1'b0;
    exp_byte = 8'h00;
    case (hidx)
      4'd0:    exp_byte = MAGIC[31:24];
      4'd1:    exp_byte = MAGIC[23:16];
      4'd2:    exp_byte = MAGIC[15:8];
      4'd3:    exp_byte = MAGIC[7:0];
      4'd4:    exp_byte = FORMAT;
      default: exp_byte = 8'h00;
    endcase
    if (udp_rx_en) begin
      cnt_nxt = (hidx == 4'hF) ? hidx : hidx + 4'd1;
      hdr_bad = (hidx < 4'd5) && (udp_idata != exp_byte);
      case (hidx)
        4'd5:    h_nxt[15:8] = udp_idata;
        4'd6:    h_nxt[7:0]  = udp_idata;
        4'd7:    v_nxt[15:8] = udp_idata;
        4'd8:    v_nxt[7:0]  = udp_idata;
        default: ;
      endcase
    end
    hdr_ok = (cnt_nxt == 4'd9) && (h_nxt != 16'd0) && (h_nxt <= MAX_H16) &&
             (v_nxt != 16'd0) && (v_nxt <= MAX_V16);
  end

  // Line accounting, with the current byte folded in so a coincident done sees it.
  logic        at_end;
  logic        pair_fire;
  logic [10:0] x_after;
  logic        ovf_after;
  logic        line_bad;
  logic        last_line;

  always_comb begin
    at_end    = ({5'd0, x} == img_h);
    pair_fire = udp_rx_en && !at_end && phase;
    x_after   = pair_fire ? x + 11'd1 : x;
    ovf_after = ovf | (udp_rx_en & at_end);
    line_bad  = ({5'd0, x_after} != img_h) || ovf_after;
    last_line = ({5'd0, y} == img_v - 16'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= 4'd0;
      hdr_h      <= 16'd0;
      hdr_v      <= 16'd0;
      x          <= 11'd0;
      y          <= 11'd0;
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      ovf        <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 16'd0;
      pix_x      <= 11'd0;
      pix_y      <= 11'd0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
      hdr_lock   <= 1'b0;
      img_h      <= 16'd0;
      img_v      <= 16'd0;
      err_hdr    <= 1'b0;
      err_line   <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      err_hdr    <= 1'b0;
      err_line   <= 1'b0;
      frame_done <= eol && ({5'd0, pix_y} == img_v - 16'd1);

      if (resync) begin
        state      <= IDLE;
        hdr_lock   <= 1'b0;
        x          <= 11'd0;
        y          <= 11'd0;
        phase      <= 1'b0;
        ovf        <= 1'b0;
        byte_idx   <= 4'd0;
        frame_done <= 1'b0;
      end else begin
        case (state)
          IDLE, HDR: begin
            if (state == HDR || udp_rx_en) begin
              byte_idx <= cnt_nxt;
              hdr_h    <= h_nxt;
              hdr_v    <= v_nxt;
              if (hdr_bad) begin
                err_hdr <= 1'b1;
                state   <= udp_rx_done ? IDLE : DROP;
              end else if (udp_rx_done) begin
                if (hdr_ok) begin
                  img_h    <= h_nxt;
                  img_v    <= v_nxt;
                  hdr_lock <= 1'b1;
                  x        <= 11'd0;
                  y        <= 11'd0;
                  phase    <= 1'b0;
                  ovf      <= 1'b0;
                  state    <= LINE;
                end else begin
                  err_hdr <= 1'b1;
                  state   <= IDLE;
                end
              end else begin
                state <= HDR;
              end
            end
          end

          DROP: begin
            if (udp_rx_done) state <= IDLE;
          end

          LINE: begin
            if (udp_rx_en) begin
              if (at_end) begin
                ovf <= 1'b1;
              end else if (!phase) begin
                hi_byte <= udp_idata;
                phase   <= 1'b1;
              end else begin
                pix_valid <= 1'b1;
                pix_data  <= {hi_byte, udp_idata};
                pix_x     <= x;
                pix_y     <= y;
                sof       <= (x == 11'd0) && (y == 11'd0);
                eol       <= ({5'd0, x} == img_h - 16'd1);
                x         <= x_after;
                phase     <= 1'b0;
              end
            end
            // End of packet always closes the line, whole or not.
            if (udp_rx_done) begin
              err_line <= line_bad;
              x        <= 11'd0;
              phase    <= 1'b0;
              ovf      <= 1'b0;
              y        <= last_line ? 11'd0 : y + 11'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
